// File: rtl/sdfm_pkg.sv
// Shared definitions for the SDFM register-map bus scheduler.
package sdfm_pkg;

  // Bus sequencer states (legacy 2-bit encoding)
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_STROBE = 2'd2;
  localparam logic [1:0] ST_HOLD   = 2'd3;

  // Default device page and FDATA0 offset for auto-reads
  localparam logic [7:0] DEF_DEV_ADDR   = 8'h07;
  localparam logic [7:0] DEF_FDATA_BASE = 8'h24;

  // Byte stride between consecutive FDATAx registers
  localparam logic [7:0] REG_STRIDE = 8'd4;

  // Low address byte of FDATA<ch>
  function automatic logic [7:0] fdata_offset(input logic [7:0] base, input logic [7:0] ch);
    return base + ch * REG_STRIDE;
  endfunction

endpackage

// File: rtl/sdfm_tgl_sync.sv
// Brings one SYSCLK-domain toggle into EXTCLK and flags each flip as a
// one-cycle edge pulse (two synchronizer flops, one delay flop, XOR).
module sdfm_tgl_sync (
  input  logic EXTCLK,
  input  logic EXTRSTn,
  input  logic tgl_in,
  output logic edge_out
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic dly_q, dly_d;

  // Next-state of the synchronizer chain
  always_comb begin
    meta_d = tgl_in;
    sync_d = meta_q;
    dly_d  = sync_q;
  end

  // Synchronizer and delay flops
  always_ff @(posedge EXTCLK or negedge EXTRSTn) begin
    if (!EXTRSTn) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      dly_q  <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      dly_q  <= dly_d;
    end
  end

  assign edge_out = sync_q ^ dly_q;

endmodule

// File: rtl/sdfm_bus_sched.sv
// Owns the SDFM register-map bus and shares it between the host port and
// the FDATA auto-read engine. Every access is SETUP, STROBE (STRB_CYC
// cycles), HOLD, followed by at least one IDLE cycle for arbitration.
//
//   state  | meaning
//   IDLE   | bus parked, ADDR keeps last value; arbitration happens here
//   SETUP  | ADDR valid, write data driven, no strobe yet
//   STROBE | WR or RD asserted; read data sampled on the last edge
//   HOLD   | strobe released, ADDR/DATA held; host_ack or dma_valid high
module sdfm_bus_sched
  import sdfm_pkg::*;
#(
  parameter logic [7:0]  DEV_ADDR   = DEF_DEV_ADDR,
  parameter logic [7:0]  FDATA_BASE = DEF_FDATA_BASE,
  parameter int unsigned STRB_CYC   = 2,
  parameter int unsigned NCH        = 2,
  localparam int unsigned CHW       = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic            EXTCLK,
  input  logic            EXTRSTn,
  input  logic            host_req,
  input  logic            host_we,
  input  logic [15:0]     host_addr,
  input  logic [31:0]     host_wdata,
  output logic            host_ack,
  output logic [31:0]     host_rdata,
  input  logic [NCH-1:0]  fdata_tgl,
  output logic            dma_valid,
  output logic [CHW-1:0]  dma_ch,
  output logic [31:0]     dma_data,
  output logic [NCH-1:0]  dma_ovf,
  input  logic [NCH-1:0]  ovf_clr,
  output logic            busy,
  output logic [15:0]     ADDR,
  output logic            WR,
  output logic            RD,
  inout  wire  [31:0]     DATA
);

  logic [1:0]     state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [15:0]    addr_q, addr_d;
  logic           we_q, we_d;
  logic [31:0]    wdata_q, wdata_d;
  logic           is_dma_q, is_dma_d;
  logic [CHW-1:0] ch_q, ch_d;
  logic           last_dma_q, last_dma_d;
  logic [NCH-1:0] pend_q, pend_d;
  logic [NCH-1:0] ovf_q, ovf_d;
  logic [1:0]     wu_q, wu_d;
  logic [31:0]    host_rdata_q, host_rdata_d;
  logic [31:0]    dma_data_q, dma_data_d;
  logic [CHW-1:0] dma_ch_q, dma_ch_d;

  logic [NCH-1:0] tgl_edge, edge_ok, grant_vec;
  logic [CHW-1:0] dma_sel;
  logic           wu_done, dma_req, grant_host, grant_dma, last_strobe;

  for (genvar gi = 0; gi < NCH; gi++) begin : g_sync
    sdfm_tgl_sync u_sync (
      .EXTCLK   (EXTCLK),
      .EXTRSTn  (EXTRSTn),
      .tgl_in   (fdata_tgl[gi]),
      .edge_out (tgl_edge[gi])
    );
  end

  // Warm-up: a toggle input already high at reset release would look like
  // an edge, so edges are masked until the chain has been refilled.
  always_comb begin
    wu_done = (wu_q == 2'd3);
    wu_d    = wu_done ? wu_q : wu_q + 2'd1;
    edge_ok = tgl_edge & {NCH{wu_done}};
  end

  // Lowest-index pending channel
  always_comb begin
    dma_sel = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (pend_q[i]) dma_sel = CHW'(i);
    end
    dma_req = |pend_q;
  end

  // Round-robin between host and DMA, evaluated only while IDLE
  always_comb begin
    grant_host = 1'b0;
    grant_dma  = 1'b0;
    if (state_q == ST_IDLE) begin
      if (host_req && (!dma_req || last_dma_q)) grant_host = 1'b1;
      else if (dma_req)                          grant_dma  = 1'b1;
    end
    grant_vec = grant_dma ? (NCH'(1) << dma_sel) : '0;
  end

  // Pending and sticky overrun; a fresh edge on the grant edge re-arms pending
  always_comb begin
    pend_d = edge_ok | (pend_q & ~grant_vec);
    ovf_d  = (ovf_q & ~ovf_clr) | (edge_ok & pend_q & ~grant_vec);
  end

  // Bus sequencer and read-data capture
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    is_dma_d     = is_dma_q;
    ch_d         = ch_q;
    last_dma_d   = last_dma_q;
    host_rdata_d = host_rdata_q;
    dma_data_d   = dma_data_q;
    dma_ch_d     = dma_ch_q;
    last_strobe  = (state_q == ST_STROBE) && (cnt_q == 4'd0);

    case (state_q)
      ST_IDLE: begin
        if (grant_host) begin
          state_d    = ST_SETUP;
          is_dma_d   = 1'b0;
          last_dma_d = 1'b0;
          addr_d     = host_addr;
          we_d       = host_we;
          wdata_d    = host_wdata;
        end else if (grant_dma) begin
          state_d    = ST_SETUP;
          is_dma_d   = 1'b1;
          last_dma_d = 1'b1;
          addr_d     = {DEV_ADDR, fdata_offset(FDATA_BASE, 8'(dma_sel))};
          we_d       = 1'b0;
          ch_d       = dma_sel;
        end
      end
      ST_SETUP: begin
        state_d = ST_STROBE;
        cnt_d   = 4'(STRB_CYC - 1);
      end
      ST_STROBE: begin
        if (cnt_q == 4'd0) state_d = ST_HOLD;
        else               cnt_d   = cnt_q - 4'd1;
      end
      default: state_d = ST_IDLE;
    endcase

    if (last_strobe && !we_q) begin
      if (is_dma_q) begin
        dma_data_d = DATA;
        dma_ch_d   = ch_q;
      end else begin
        host_rdata_d = DATA;
      end
    end
  end

  // State registers; async reset aborts any access in flight
  always_ff @(posedge EXTCLK or negedge EXTRSTn) begin
    if (!EXTRSTn) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 4'd0;
      addr_q       <= 16'h0;
      we_q         <= 1'b0;
      wdata_q      <= 32'h0;
      is_dma_q     <= 1'b0;
      ch_q         <= '0;
      last_dma_q   <= 1'b1;
      pend_q       <= '0;
      ovf_q        <= '0;
      wu_q         <= 2'd0;
      host_rdata_q <= 32'h0;
      dma_data_q   <= 32'h0;
      dma_ch_q     <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      is_dma_q     <= is_dma_d;
      ch_q         <= ch_d;
      last_dma_q   <= last_dma_d;
      pend_q       <= pend_d;
      ovf_q        <= ovf_d;
      wu_q         <= wu_d;
      host_rdata_q <= host_rdata_d;
      dma_data_q   <= dma_data_d;
      dma_ch_q     <= dma_ch_d;
    end
  end

  assign busy       = (state_q != ST_IDLE);
  assign ADDR       = addr_q;
  assign WR         = (state_q == ST_STROBE) && we_q;
  assign RD         = (state_q == ST_STROBE) && !we_q;
  assign DATA       = (we_q && busy) ? wdata_q : 32'bz;
  assign host_ack   = (state_q == ST_HOLD) && !is_dma_q;
  assign dma_valid  = (state_q == ST_HOLD) && is_dma_q;
  assign host_rdata = host_rdata_q;
  assign dma_data   = dma_data_q;
  assign dma_ch     = dma_ch_q;
  assign dma_ovf    = ovf_q;

endmodule

// File: doc/sdfm_bus_sched.md
# sdfm_bus_sched

Bus scheduler/arbiter in the EXTCLK domain that owns the SDFM register-map bus (ADDR, WR, RD, DATA). It shares the bus between a host port and an internal auto-read engine. The auto-read engine fetches each FDATAx register after the SYSCLK-domain filter signals a new sample. It sits between the external host logic and the register map, and generates correctly sequenced setup/strobe/hold cycles with a programmable strobe width.

## Interface
Parameters:
- DEV_ADDR, 8'h07: device page placed in ADDR[15:8] for auto-reads.
- FDATA_BASE, 8'h24: ADDR[7:0] of FDATA0; channel i is at FDATA_BASE + 4*i.
- STRB_CYC, 2: width of the WR/RD strobe in EXTCLK cycles; legal range 1..15.
- NCH, 2: number of filter channels.

Ports:
- Reset is EXTRSTn, asynchronous, active-low. Clock is EXTCLK.
- EXTCLK  in  1  bus/host clock.
- EXTRSTn  in  1  async active-low reset.
- host_req  in  1  host access request; level, held until host_ack.
- host_we  in  1  1 = write, 0 = read; stable while host_req.
- host_addr  in  16  register address; stable while host_req.
- host_wdata  in  32  write data; stable while host_req.
- host_ack  out  1  one-cycle completion pulse.
- host_rdata  out  32  read data; valid with host_ack, held until next host read.
- fdata_tgl  in  NCH  per-channel toggle from SYSCLK domain; flips once per filter update.
- dma_valid  out  1  one-cycle pulse: auto-read sample available.
- dma_ch  out  log2(NCH) min 1  channel of dma_data.
- dma_data  out  32  auto-read FDATAx value, valid with dma_valid.
- dma_ovf  out  NCH  sticky per-channel overrun flag.
- ovf_clr  in  NCH  synchronous clear of dma_ovf bits.
- busy  out  1  high whenever the FSM is not IDLE.
- ADDR  out  16  register-map address.
- WR  out  1  write strobe.
- RD  out  1  read strobe.
- DATA  inout  32  register-map data bus.

## Operation
- FSM states are IDLE, SETUP, STROBE, HOLD.
  - IDLE: arbitration. On a grant, go to SETUP.
  - SETUP: 1 cycle. Go to STROBE.
  - STROBE: STRB_CYC cycles, counted by a 4-bit counter. Go to HOLD.
  - HOLD: 1 cycle. Go to IDLE.
- ADDR is latched at grant and held through HOLD. It keeps its last value in IDLE.
- WR is high only in STROBE of a write. RD is high only in STROBE of a read.
- DATA is driven with the latched wdata in SETUP, STROBE and HOLD of writes. It is Z at all other times.
- Read data is sampled from DATA on the rising edge that ends the last STROBE cycle.
- host_ack or dma_valid is high during HOLD. host_rdata or dma_data is updated at the same edge the data is sampled. Host writes also get host_ack; host_rdata is unchanged by writes.
- Toggle crossing: per channel, a 2-flop synchronizer, a third flop, and an XOR edge detect.
  - A detected edge sets pending[i].
  - Warm-up: edges are ignored for 3 cycles after reset release, via a 2-bit counter. This suppresses false edges when fdata_tgl is 1 at reset.
- Arbitration happens in IDLE only.
  - Requesters are host (host_req) and DMA (any pending bit).
  - If both request, round-robin: grant the requester not granted last. After reset, "last" = DMA, so the host wins first.
  - Within DMA, the lowest pending index wins.
  - pending[i] clears at the grant edge.
- Boundary cases:
  - Edge detected on the same edge pending[i] is granted: pending stays 1, no overrun.
  - Edge detected while pending[i]=1 and not being granted: dma_ovf[i] is set, and pending stays 1.
  - ovf_clr[i] and a new overrun on the same edge: set wins.
  - host_req dropped before ack is illegal; behaviour is undefined but the bus is never corrupted, because a started transaction always completes.
  - Host addresses are not decoded; any address is issued as given.
- Async reset mid-transaction: WR and RD go low immediately, DATA goes Z, the FSM returns to IDLE, pending, dma_ovf and counters clear, and no ack or valid is issued.
- Reset values: ADDR 0, WR 0, RD 0, DATA Z, host_ack 0, host_rdata 0, dma_valid 0, dma_ch 0, dma_data 0, dma_ovf 0, busy 0.

## Timing
- Requests are sampled on the edge at which the FSM is in IDLE; call it edge k.
  - SETUP is cycle k+1.
  - STROBE spans cycles k+2 .. k+1+STRB_CYC.
  - HOLD is cycle k+2+STRB_CYC.
  - IDLE is cycle k+3+STRB_CYC.
- Transaction length is STRB_CYC+2 cycles plus a mandatory IDLE cycle. Back-to-back throughput is one access per STRB_CYC+3 cycles (5 at the default).
- Toggle to pending latency is 3 EXTCLK edges.

## Structure
- Shared package sdfm_pkg holds the FSM state enum (IDLE/SETUP/STROBE/HOLD), the default DEV_ADDR and FDATA_BASE constants, and the 4-byte register stride.
- Sub-module sdfm_tgl_sync contains the 2-flop synchronizer, delay flop and XOR edge detect. It is instantiated once per channel.
- Warm-up counter, pending/overrun logic, arbiter and FSM are in the top module.

## Test plan
- Host write 0x0708 with data 0x3 at STRB_CYC=2 -> ADDR=0x0708 from cycle k+1; WR high in cycles k+2..k+3; DATA=0x3 in k+1..k+4; host_ack in k+4; RD never high.
- Host read 0x0724 while the bench drives DATA=0xDEADBEEF under RD -> RD high for 2 cycles; host_ack with host_rdata=0xDEADBEEF; DATA otherwise Z.
- Toggle fdata_tgl[1] -> 3 edges later pending is set; read at ADDR=0x0728; dma_valid with dma_ch=1; dma_ovf=0.
- host_req held and both channels toggled together -> grant order host, ch0, host, ch1; each transaction separated by 1 IDLE cycle.
- Two toggles on ch0 while the host occupies the bus -> dma_ovf[0]=1; a single read is issued; ovf_clr[0] pulse -> dma_ovf[0]=0.
- EXTRSTn asserted mid-STROBE of a write, with fdata_tgl=1 at release -> WR low and DATA Z immediately; no host_ack; no spurious auto-read after release.
